// File: rtl/fpa_align_kpg.sv
// Operand ordering and mantissa alignment ahead of the FP adder's prefix carry network.
// Define FPA_ALIGN_BARREL_EN to replace the 1-bit/cycle shifter with a single-cycle barrel shift.
module fpa_align_kpg #(
    parameter int          W     = 32,
    parameter logic [7:0]  KPG_K = 8'h6B,
    parameter logic [7:0]  KPG_P = 8'h70,
    parameter logic [7:0]  KPG_G = 8'h67
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [31:0]         a,
    input  logic [31:0]         b,
    input  logic                in_valid,
    output logic                in_ready,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [W-1:0]        ma,
    output logic [W-1:0]        mb,
    output logic [7:0]          big_exp,
    output logic                sign_out,
    output logic                eff_sub,
    output logic                special,
    output logic [W-1:0][7:0]   kpg
);

    localparam int CW = $clog2(W);

    typedef enum logic [1:0] {IDLE, SHIFT, HOLD} state_t;

    state_t                state_reg;
    logic                  in_ready_reg, out_valid_reg;
    logic [W-1:0]          ma_reg, mb_reg;
    logic [7:0]            big_exp_reg;
    logic                  sign_reg, sub_reg, special_reg;
    logic [W-1:0][7:0]     kpg_reg;

    // working copy of the operation while the small mantissa is being shifted
    logic [W-1:0]          wa_reg, ws_reg;
    logic [7:0]            wexp_reg;
    logic                  wsign_reg, wsub_reg, wspec_reg;
    logic [CW-1:0]         cnt_reg;

    // operand decode and magnitude ordering
    logic [7:0]   ea_eff, eb_eff, big_e, small_e, diff;
    logic [W-1:0] ma_in, mb_in, big_m, small_m;
    logic         a_big;
    logic [CW-1:0] shift_init;

    always_comb begin
        ea_eff     = (a[30:23] == 8'd0) ? 8'd1 : a[30:23];
        eb_eff     = (b[30:23] == 8'd0) ? 8'd1 : b[30:23];
        ma_in      = {2'b00, |a[30:23], a[22:0], 6'b0};
        mb_in      = {2'b00, |b[30:23], b[22:0], 6'b0};
        a_big      = {ea_eff, ma_in} >= {eb_eff, mb_in};
        big_m      = a_big ? ma_in  : mb_in;
        small_m    = a_big ? mb_in  : ma_in;
        big_e      = a_big ? ea_eff : eb_eff;
        small_e    = a_big ? eb_eff : ea_eff;
        diff       = big_e - small_e;
        shift_init = (diff > 8'(W - 1)) ? CW'(W - 1) : diff[CW-1:0];
    end

    logic [W-1:0]      mb_next;
    logic [W-1:0][7:0] kpg_next;

    assign mb_next = wsub_reg ? ~ws_reg : ws_reg;

    genvar gi;
    generate
        for (gi = 1; gi < W; gi++) begin : g_kpg
            assign kpg_next[gi] = (wa_reg[gi] & mb_next[gi])   ? KPG_G :
                                  (!wa_reg[gi] & !mb_next[gi]) ? KPG_K : KPG_P;
        end
    endgenerate

    // subtraction folds the +1 of two's complement into bit 0 as a carry-in
    assign kpg_next[0] = wsub_reg ? ((wa_reg[0] | mb_next[0]) ? KPG_G : KPG_K) :
                         (wa_reg[0] & mb_next[0])   ? KPG_G :
                         (!wa_reg[0] & !mb_next[0]) ? KPG_K : KPG_P;

    logic         finish;
    logic [W-1:0] shift_m;

`ifdef FPA_ALIGN_BARREL_EN
    logic shifted_reg;
    logic sticky;

    // bit 0 collects every bit at or below the shift amount, matching the iterative sticky
    always_comb begin
        sticky = 1'b0;
        for (int i = 0; i < W; i++) begin
            if (i <= int'(cnt_reg)) sticky = sticky | ws_reg[i];
        end
        shift_m    = ws_reg >> cnt_reg;
        shift_m[0] = sticky;
    end
    assign finish = shifted_reg;
`else
    assign shift_m = {1'b0, ws_reg[W-1:2], ws_reg[1] | ws_reg[0]};
    assign finish  = (cnt_reg == '0);
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= IDLE;
            in_ready_reg  <= 1'b1;
            out_valid_reg <= 1'b0;
            ma_reg        <= '0;
            mb_reg        <= '0;
            big_exp_reg   <= '0;
            sign_reg      <= 1'b0;
            sub_reg       <= 1'b0;
            special_reg   <= 1'b0;
            kpg_reg       <= {W{KPG_K}};
            wa_reg        <= '0;
            ws_reg        <= '0;
            wexp_reg      <= '0;
            wsign_reg     <= 1'b0;
            wsub_reg      <= 1'b0;
            wspec_reg     <= 1'b0;
            cnt_reg       <= '0;
`ifdef FPA_ALIGN_BARREL_EN
            shifted_reg   <= 1'b0;
`endif
        end else begin
            case (state_reg)
                IDLE: begin
                    if (in_valid) begin
                        wa_reg       <= big_m;
                        ws_reg       <= small_m;
                        wexp_reg     <= big_e;
                        wsign_reg    <= a_big ? a[31] : b[31];
                        wsub_reg     <= a[31] ^ b[31];
                        wspec_reg    <= (&a[30:23]) | (&b[30:23]);
                        cnt_reg      <= shift_init;
                        in_ready_reg <= 1'b0;
                        state_reg    <= SHIFT;
`ifdef FPA_ALIGN_BARREL_EN
                        shifted_reg  <= 1'b0;
`endif
                    end
                end
                SHIFT: begin
                    if (finish) begin
                        ma_reg        <= wa_reg;
                        mb_reg        <= mb_next;
                        big_exp_reg   <= wexp_reg;
                        sign_reg      <= wsign_reg;
                        sub_reg       <= wsub_reg;
                        special_reg   <= wspec_reg;
                        kpg_reg       <= kpg_next;
                        out_valid_reg <= 1'b1;
                        state_reg     <= HOLD;
                    end else begin
                        ws_reg      <= shift_m;
`ifdef FPA_ALIGN_BARREL_EN
                        shifted_reg <= 1'b1;
`else
                        cnt_reg     <= cnt_reg - 1'b1;
`endif
                    end
                end
                HOLD: begin
                    if (out_ready) begin
                        out_valid_reg <= 1'b0;
                        in_ready_reg  <= 1'b1;
                        state_reg     <= IDLE;
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign in_ready  = in_ready_reg;
    assign out_valid = out_valid_reg;
    assign ma        = ma_reg;
    assign mb        = mb_reg;
    assign big_exp   = big_exp_reg;
    assign sign_out  = sign_reg;
    assign eff_sub   = sub_reg;
    assign special   = special_reg;
    assign kpg       = kpg_reg;

endmodule

// File: tb/tb_fpa_align_kpg.sv
// Scoreboarded bench for fpa_align_kpg: directed test-plan cases plus randomized operand pairs.
module tb_fpa_align_kpg;

    localparam logic [7:0] K = 8'h6B;
    localparam logic [7:0] P = 8'h70;
    localparam logic [7:0] G = 8'h67;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic [31:0]      a = '0, b = '0;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic             out_valid;
    logic             out_ready = 1'b0;
    logic [31:0]      ma, mb;
    logic [7:0]       big_exp;
    logic             sign_out, eff_sub, special;
    logic [31:0][7:0] kpg;

    fpa_align_kpg dut (
        .clk(clk), .rst(rst), .a(a), .b(b),
        .in_valid(in_valid), .in_ready(in_ready),
        .out_valid(out_valid), .out_ready(out_ready),
        .ma(ma), .mb(mb), .big_exp(big_exp),
        .sign_out(sign_out), .eff_sub(eff_sub), .special(special),
        .kpg(kpg)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0]  ma, mb;
        logic [7:0]   e;
        logic         s, sub, spec;
        logic [255:0] kpg;
        int           lat;
        int           acc;
    } exp_t;

    exp_t q[$];
    int   checks = 0, errors = 0, cyc = 0, mode = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [255:0] got, input logic [255:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %h want %h", name, got, want);
        end
    endtask

    // Reference: decode, order by magnitude, shift with sticky, invert, classify bits.
    function automatic exp_t model(input logic [31:0] x, input logic [31:0] y);
        exp_t        r;
        logic [7:0]  ex, ey, c;
        logic [31:0] mx, my, ms;
        logic [63:0] wide;
        logic        big_a, sticky;
        int          d, n;
        ex    = (x[30:23] == 8'd0) ? 8'd1 : x[30:23];
        ey    = (y[30:23] == 8'd0) ? 8'd1 : y[30:23];
        mx    = {2'b00, x[30:23] != 8'd0, x[22:0], 6'b0};
        my    = {2'b00, y[30:23] != 8'd0, y[22:0], 6'b0};
        big_a = (ex > ey) || ((ex == ey) && (mx >= my));
        r.ma  = big_a ? mx : my;
        ms    = big_a ? my : mx;
        r.e   = big_a ? ex : ey;
        r.s   = big_a ? x[31] : y[31];
        d     = big_a ? (int'(ex) - int'(ey)) : (int'(ey) - int'(ex));
        n     = (d > 31) ? 31 : d;
        wide  = {32'b0, ms};
        sticky = (wide & ((64'd1 << (n + 1)) - 64'd1)) != 64'd0;
        r.mb  = (ms >> n) | {31'b0, sticky};
        r.sub = x[31] ^ y[31];
        if (r.sub) r.mb = ~r.mb;
        r.spec = (x[30:23] == 8'hFF) || (y[30:23] == 8'hFF);
        r.kpg  = '0;
        for (int i = 0; i < 32; i++) begin
            if (i == 0 && r.sub)               c = (r.ma[0] | r.mb[0]) ? G : K;
            else if (r.ma[i] && r.mb[i])       c = G;
            else if (!r.ma[i] && !r.mb[i])     c = K;
            else                               c = P;
            r.kpg[i*8 +: 8] = c;
        end
`ifdef FPA_ALIGN_BARREL_EN
        r.lat = 2;
`else
        r.lat = n + 1;
`endif
        r.acc = 0;
        return r;
    endfunction

    // Called on a falling edge; returns on the falling edge after the accepting rising edge.
    task automatic send(input logic [31:0] x, input logic [31:0] y);
        exp_t e;
        bit   ok;
        ok = 1'b0;
        e  = model(x, y);
        a  = x;
        b  = y;
        in_valid = 1'b1;
        for (int t = 0; t < 300 && !ok; t++) begin
            if (in_ready) begin
                ok    = 1'b1;
                e.acc = cyc + 1;
                q.push_back(e);
            end
            @(negedge clk);
        end
        in_valid = 1'b0;
        if (!ok) begin
            checks++;
            errors++;
            $display("FAIL accept_timeout: in_ready got 0 want 1 (a=%h b=%h)", x, y);
        end
    endtask

    task automatic wait_valid(input string name);
        int t;
        t = 0;
        while (!out_valid && t < 100) begin
            @(negedge clk);
            t++;
        end
        if (!out_valid) begin
            checks++;
            errors++;
            $display("FAIL %s_timeout: out_valid got 0 want 1", name);
        end
    endtask

    initial begin
        forever begin
            @(negedge clk);
            case (mode)
                0:       out_ready = ($urandom_range(3) != 0);
                1:       out_ready = 1'b0;
                default: out_ready = 1'b1;
            endcase
        end
    end

    // Monitor: pop on each new result, then hold every output against it while valid.
    exp_t cur;
    bit   have = 1'b0;
    logic prev_v = 1'b0;
    always @(negedge clk) begin
        if (rst) begin
            have   = 1'b0;
            prev_v = 1'b0;
        end else begin
            if (out_valid && !prev_v) begin
                if (q.size() == 0) begin
                    checks++;
                    errors++;
                    have = 1'b0;
                    $display("FAIL unexpected_output: out_valid got 1 want 0");
                end else begin
                    cur  = q.pop_front();
                    have = 1'b1;
                    chk("latency", 256'(cyc - cur.acc), 256'(cur.lat));
                    $display("txn ma=%h mb=%h big_exp=%h sign=%b sub=%b special=%b lat=%0d",
                             ma, mb, big_exp, sign_out, eff_sub, special, cyc - cur.acc);
                end
            end
            if (out_valid && have) begin
                chk("ma", 256'(ma), 256'(cur.ma));
                chk("mb", 256'(mb), 256'(cur.mb));
                chk("big_exp", 256'(big_exp), 256'(cur.e));
                chk("sign_out", 256'(sign_out), 256'(cur.s));
                chk("eff_sub", 256'(eff_sub), 256'(cur.sub));
                chk("special", 256'(special), 256'(cur.spec));
                chk("kpg", kpg, cur.kpg);
                chk("in_ready_busy", 256'(in_ready), 256'(0));
            end
            prev_v = out_valid;
        end
    end

    initial begin
        logic [31:0] x, y;
        int          e, t;

        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("rst_in_ready", 256'(in_ready), 256'(1));
        chk("rst_out_valid", 256'(out_valid), 256'(0));
        chk("rst_ma_mb", {ma, mb}, 256'(0));
        chk("rst_flags", {big_exp, sign_out, eff_sub, special}, 256'(0));
        chk("rst_kpg", kpg, {32{K}});

        send(32'h3F800000, 32'h3F800000);
        wait_valid("one_plus_one");
        chk("d1_mb", 256'(mb), 256'(32'h20000000));
        chk("d1_kpg29", 256'(kpg[29]), 256'(G));

        send(32'h3F000000, 32'h3F800000);
        wait_valid("one_plus_half");
        chk("d2_ma", 256'(ma), 256'(32'h20000000));
        chk("d2_mb", 256'(mb), 256'(32'h10000000));

        send(32'h3F800000, 32'hBF800000);
        wait_valid("one_minus_one");
        chk("d3_mb", 256'(mb), 256'(32'hDFFFFFFF));
        chk("d3_kpg0", 256'(kpg[0]), 256'(G));
        chk("d3_sign", 256'(sign_out), 256'(0));

        send(32'h3F800000, 32'h2B800000);
        wait_valid("large_gap");
        chk("d4_mb", 256'(mb), 256'(32'h00000001));
        chk("d4_kpg0", 256'(kpg[0]), 256'(P));

        // backpressure: stall in HOLD while a new pair waits at the input
        @(posedge clk); #1 mode = 1;
        @(negedge clk);
        send(32'h3F800000, 32'h3F800000);
        wait_valid("bp");
        a = 32'h40400000;
        b = 32'hC0000000;
        in_valid = 1'b1;
        repeat (5) begin
            @(negedge clk);
            chk("bp_in_ready", 256'(in_ready), 256'(0));
            chk("bp_out_valid", 256'(out_valid), 256'(1));
        end
        @(posedge clk); #1 mode = 2;
        @(negedge clk);
        @(negedge clk);
        chk("bp_release_valid", 256'(out_valid), 256'(0));
        chk("bp_release_ready", 256'(in_ready), 256'(1));
        send(32'h40400000, 32'hC0000000);
        @(posedge clk); #1 mode = 0;
        @(negedge clk);
        wait_valid("bp_second");

        // reset in the middle of a long shift
        t = 0;
        while (out_valid && t < 100) begin @(negedge clk); t++; end
        send(32'h3F800000, 32'h2B800000);
        repeat (8) @(negedge clk);
        @(posedge clk); #1 rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        q.delete();
        @(negedge clk);
        chk("mid_rst_out_valid", 256'(out_valid), 256'(0));
        chk("mid_rst_in_ready", 256'(in_ready), 256'(1));
        chk("mid_rst_kpg", kpg, {32{K}});
        send(32'h3F800000, 32'h3F800000);
        wait_valid("post_rst");

        for (int n = 0; n < 60; n++) begin
            x = $urandom;
            y = $urandom;
            case ($urandom_range(3))
                0: ;
                1: y[30:23] = x[30:23];
                2: begin
                    e = int'(x[30:23]) + int'($urandom_range(40)) - 20;
                    if (e < 0)   e = 0;
                    if (e > 255) e = 255;
                    y[30:23] = e[7:0];
                end
                default: x[30:23] = ($urandom_range(1) != 0) ? 8'h00 : 8'hFF;
            endcase
            send(x, y);
            repeat ($urandom_range(2)) @(negedge clk);
        end

        t = 0;
        while ((q.size() != 0 || out_valid) && t < 2000) begin
            @(negedge clk);
            t++;
        end
        chk("scoreboard_drained", 256'(q.size()), 256'(0));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
